ahb3lite_sram_ws: RTL

AHB3LITE_SRAM_WS -- requirements
Module: ahb3lite_sram_ws

---
 rtl/ahb3lite_sram_ws.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ahb3lite_sram_ws.sv
// AHB3-Lite single-port SRAM slave: zero-wait writes, WAIT_STATES read wait states.
// Optional out-of-range ERROR response enabled by macro AHB3LITE_SRAM_ERR_RESP_EN.
module ahb3lite_sram_ws #(
    parameter int MEM_DEPTH   = 256,
    parameter int HADDR_SIZE  = 32,
    parameter int HDATA_SIZE  = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    output logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP
);
    // state | meaning
    // IDLE  | no stall; accepts address phases, last read data phase ends here
    // RWAIT | read wait states, HREADYOUT low until counter reaches 0
    // ERR1  | first ERROR cycle, HREADYOUT low
    // ERR2  | second ERROR cycle, HREADYOUT high, may accept a new transfer

    localparam int NB   = HDATA_SIZE / 8;
    localparam int BA   = $clog2(NB);
    localparam int BA_W = (BA > 0) ? BA : 1;
    localparam int IW   = $clog2(MEM_DEPTH);
    localparam int CW   = 3;

    typedef enum logic [1:0] {IDLE, RWAIT, ERR1, ERR2} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  wr_pend_q, wr_pend_d;
    logic [IW-1:0]         wr_idx_q, wr_idx_d;
    logic [NB-1:0]         wr_be_q, wr_be_d;
    logic [HDATA_SIZE-1:0] hrdata_q, hrdata_d;
    logic [HDATA_SIZE-1:0] mem_q [MEM_DEPTH];

    logic                  hreadyout;
    logic                  accept;
    logic                  addr_err;
    logic [IW-1:0]         idx;
    logic [BA_W-1:0]       addr_lo;
    logic [NB-1:0]         be;
    logic [HDATA_SIZE-1:0] rd_word;
    logic                  unused_ok;

    assign hreadyout = (state_q != RWAIT) && (state_q != ERR1);
    assign accept    = HSEL & HREADY & HTRANS[1] & hreadyout;
    assign idx       = HADDR[BA +: IW];

`ifdef AHB3LITE_SRAM_ERR_RESP_EN
    localparam int BYTE_AW = $clog2(MEM_DEPTH * NB);
    assign addr_err = ((HADDR >> BYTE_AW) != '0);
    assign HRESP    = (state_q == ERR1) || (state_q == ERR2);
`else
    assign addr_err = 1'b0;
    assign HRESP    = 1'b0;
`endif

    always_comb begin
        addr_lo = '0;
        if (BA > 0) addr_lo = HADDR[BA_W-1:0];
    end

    // A lane is enabled when it matches the address in every bit above the transfer size.
    always_comb begin
        be = '0;
        for (int i = 0; i < NB; i++)
            be[i] = (((i ^ int'(addr_lo)) >> HSIZE) == 0);
    end

    // Forward the write whose data phase is in flight so a following read sees it.
    always_comb begin
        rd_word = mem_q[idx];
        if (wr_pend_q && (wr_idx_q == idx)) begin
            for (int i = 0; i < NB; i++)
                if (wr_be_q[i]) rd_word[8*i +: 8] = HWDATA[8*i +: 8];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_pend_d = accept & HWRITE & ~addr_err;
        wr_idx_d  = accept ? idx : wr_idx_q;
        wr_be_d   = accept ? be : wr_be_q;
        hrdata_d  = (accept & ~HWRITE & ~addr_err) ? rd_word : hrdata_q;
        case (state_q)
            IDLE, ERR2: begin
                state_d = IDLE;
                if (accept) begin
                    if (addr_err) begin
                        state_d = ERR1;
                    end else if (!HWRITE && (WAIT_STATES > 0)) begin
                        state_d = RWAIT;
                        cnt_d   = CW'(WAIT_STATES - 1);
                    end
                end
            end
            RWAIT: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 3'd1;
            end
            ERR1:    state_d = ERR2;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_pend_q <= 1'b0;
            wr_idx_q  <= '0;
            wr_be_q   <= '0;
            hrdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_pend_q <= wr_pend_d;
            wr_idx_q  <= wr_idx_d;
            wr_be_q   <= wr_be_d;
            hrdata_q  <= hrdata_d;
        end
    end

    // Storage is deliberately not reset; wr_pend_q is, so a reset aborts a pending write.
    always_ff @(posedge HCLK) begin
        if (wr_pend_q) begin
            for (int i = 0; i < NB; i++)
                if (wr_be_q[i]) mem_q[wr_idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
        end
    end

    assign HRDATA    = hrdata_q;
    assign HREADYOUT = hreadyout;
    assign unused_ok = ^{HBURST, HPROT, HTRANS[0], HADDR};

endmodule
